// File: rtl/idct_block_sequencer.sv
// Ping-pong 8x8 coefficient banks feeding a 2D IDCT engine, with one output buffer streamed
// out in raster order. Define IDCT_SEQ_LEVEL_SHIFT_EN to add +128 to each sample at capture.
module idct_block_sequencer #(
  parameter int COEF_W = 12,
  parameter int PIX_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coef_valid,
  input  logic [COEF_W-1:0]    coef_data,
  output logic                 coef_ready,
  output logic                 idct_valid_in,
  output logic [64*COEF_W-1:0] idct_in,
  input  logic                 idct_valid_out,
  input  logic [64*PIX_W-1:0]  idct_out,
  output logic                 pix_valid,
  output logic [PIX_W-1:0]     pix_data,
  output logic                 pix_last,
  input  logic                 pix_ready,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshakes: a beat moves on a rising edge where valid and ready are both high;
  // ready never depends on valid in the same cycle, and valid/data hold while stalled.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e            state_q;
  logic              idct_valid_in_q;
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [5:0]        wr_idx_q, wr_idx_d;
  logic [5:0]        rd_idx_q, rd_idx_d;
  logic              obuf_full_q, obuf_full_d;

  logic [COEF_W-1:0] bank_q [2][64];
  logic [PIX_W-1:0]  obuf_q [64];
  logic [PIX_W-1:0]  cap_pix [64];

  logic coef_fire;
  logic blk_done;
  logic pix_fire;
  logic capture;
  logic rd_bank_ready;

  assign coef_ready = ~full_q[wr_bank_q];
  assign coef_fire  = coef_valid & coef_ready;
  assign blk_done   = coef_fire & (wr_idx_q == 6'd63);
  assign pix_fire   = obuf_full_q & pix_ready;
  assign capture    = (state_q == S_WAIT) & idct_valid_out;

  // Looking at the final write directly lets ISSUE follow the 64th coefficient with no bubble.
  assign rd_bank_ready = full_q[rd_bank_q] | (blk_done & (wr_bank_q == rd_bank_q));

  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    rd_bank_d   = rd_bank_q;
    obuf_full_d = obuf_full_q;
    rd_idx_d    = rd_idx_q;
    if (coef_fire) begin
      wr_idx_d = wr_idx_q + 6'd1;
      if (blk_done) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = 6'd0;
      end
    end
    // A capture frees the bank being read; the write side only ever touches the other bank.
    if (capture) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      obuf_full_d       = 1'b1;
    end
    if (pix_fire) begin
      rd_idx_d = rd_idx_q + 6'd1;
      if (rd_idx_q == 6'd63) begin
        obuf_full_d = 1'b0;
        rd_idx_d    = 6'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= 6'd0;
      rd_bank_q   <= 1'b0;
      obuf_full_q <= 1'b0;
      rd_idx_q    <= 6'd0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_idx_q    <= wr_idx_d;
      rd_bank_q   <= rd_bank_d;
      obuf_full_q <= obuf_full_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      idct_valid_in_q <= 1'b0;
    end else begin
      idct_valid_in_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rd_bank_ready && !obuf_full_q) begin
            state_q         <= S_ISSUE;
            idct_valid_in_q <= 1'b1;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (idct_valid_out) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 64; i++) begin
`ifdef IDCT_SEQ_LEVEL_SHIFT_EN
      cap_pix[i] = idct_out[i*PIX_W +: PIX_W] + PIX_W'(128);
`else
      cap_pix[i] = idct_out[i*PIX_W +: PIX_W];
`endif
    end
  end

  // Storage arrays carry no reset; the flags and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (coef_fire) bank_q[wr_bank_q][wr_idx_q] <= coef_data;
    if (capture) begin
      for (int i = 0; i < 64; i++) obuf_q[i] <= cap_pix[i];
    end
  end

  always_comb begin
    idct_in = '0;
    for (int i = 0; i < 64; i++) idct_in[i*COEF_W +: COEF_W] = bank_q[rd_bank_q][i];
  end

  assign idct_valid_in = idct_valid_in_q;
  assign pix_valid     = obuf_full_q;
  assign pix_data      = obuf_q[rd_idx_q];
  assign pix_last      = obuf_full_q & (rd_idx_q == 6'd63);
  assign busy          = (|full_q) | (state_q != S_IDLE) | obuf_full_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_idct_block_sequencer.sv
// Bench for idct_block_sequencer: behavioural engine model, random blocks, scoreboard of expected
// samples computed from the coefficients sent. Honours IDCT_SEQ_LEVEL_SHIFT_EN like the design.
module tb_idct_block_sequencer;
  localparam int COEF_W = 12;
  localparam int PIX_W  = 8;
`ifdef IDCT_SEQ_LEVEL_SHIFT_EN
  localparam logic [PIX_W-1:0] LS_LO = 8'h00;
  localparam logic [PIX_W-1:0] LS_HI = 8'hFF;
`else
  localparam logic [PIX_W-1:0] LS_LO = 8'h80;
  localparam logic [PIX_W-1:0] LS_HI = 8'h7F;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 coef_valid;
  logic [COEF_W-1:0]    coef_data;
  logic                 coef_ready;
  logic                 idct_valid_in;
  logic [64*COEF_W-1:0] idct_in;
  logic                 idct_valid_out;
  logic [64*PIX_W-1:0]  idct_out;
  logic                 pix_valid;
  logic [PIX_W-1:0]     pix_data;
  logic                 pix_last;
  logic                 pix_ready;
  logic                 busy;
  logic [1:0]           dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int long_pulse = 0;
  logic prev_vin = 1'b0;
  int last_acc_cyc = 0;
  int eng_hold = 1;

  logic [COEF_W-1:0]    blk_buf [64];
  logic [PIX_W-1:0]     exp_q [$];
  logic [PIX_W:0]       got_q [$];
  logic [64*COEF_W-1:0] eng_blk;

  idct_block_sequencer #(.COEF_W(COEF_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .rst(rst),
    .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
    .idct_valid_in(idct_valid_in), .idct_in(idct_in),
    .idct_valid_out(idct_valid_out), .idct_out(idct_out),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Engine: result sample k is the low PIX_W bits of coefficient k plus k, after 3 cycles.
  initial begin
    idct_valid_out = 1'b0;
    idct_out = '0;
    forever begin
      @(negedge clk);
      if (idct_valid_in === 1'b1) begin
        eng_blk = idct_in;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 64; k++)
          idct_out[k*PIX_W +: PIX_W] = eng_blk[k*COEF_W +: PIX_W] + PIX_W'(k);
        idct_valid_out = 1'b1;
        repeat (eng_hold) @(negedge clk);
        idct_valid_out = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (idct_valid_in === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_cyc <= cyc;
      if (prev_vin) long_pulse <= long_pulse + 1;
    end
    prev_vin <= idct_valid_in;
    if (pix_valid === 1'b1 && pix_ready === 1'b1) got_q.push_back({pix_last, pix_data});
  end

  // Reference: engine sample is a signed PIX_W value; level shift maps it to 0..255.
  function automatic logic [PIX_W-1:0] ref_pix(input logic [COEF_W-1:0] c, input int k);
    int s;
    s = (int'(c) + k) % 256;
    if (s >= 128) s = s - 256;
`ifdef IDCT_SEQ_LEVEL_SHIFT_EN
    return PIX_W'(s + 128);
`else
    return PIX_W'(s);
`endif
  endfunction

  // driver tasks
  task automatic rand_block();
    for (int k = 0; k < 64; k++) blk_buf[k] = COEF_W'($urandom);
  endtask

  task automatic push_exp();
    for (int k = 0; k < 64; k++) exp_q.push_back(ref_pix(blk_buf[k], k));
  endtask

  task automatic send_coefs(input int n, input bit gaps, output bit ok);
    bit acc;
    ok = 1'b1;
    for (int k = 0; k < n && ok; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        coef_valid = 1'b0;
        @(posedge clk); #1;
      end
      coef_valid = 1'b1;
      coef_data  = blk_buf[k];
      acc = 1'b0;
      for (int t = 0; t < 3000 && !acc; t++) begin
        @(negedge clk);
        acc = coef_ready;
        if (acc) last_acc_cyc = cyc;
        @(posedge clk); #1;
      end
      if (!acc) ok = 1'b0;
    end
    coef_valid = 1'b0;
  endtask

  task automatic wait_samples(input int n, output bit ok);
    for (int t = 0; t < 4000 && got_q.size() < n; t++) @(posedge clk);
    #1;
    ok = (got_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0; coef_valid = 1'b0; coef_data = '0; pix_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL reset_coef_ready[%0d]: got %b expected 1", p, coef_ready); end
      checks++; if (idct_valid_in !== 1'b0) begin errors++; $display("FAIL reset_idct_valid_in[%0d]: got %b expected 0", p, idct_valid_in); end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid[%0d]: got %b expected 0", p, pix_valid); end
      checks++; if (pix_last !== 1'b0) begin errors++; $display("FAIL reset_pix_last[%0d]: got %b expected 0", p, pix_last); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy[%0d]: got %b expected 0", p, busy); end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state[%0d]: got %0d expected 0", p, dbg_state); end
      rst = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dc_block();
    bit ok;
    int base, lp;
    logic [PIX_W:0] g;
    logic [PIX_W-1:0] e;
    base = pulse_cnt; lp = long_pulse;
    pix_ready = 1'b1;
    for (int k = 0; k < 64; k++) blk_buf[k] = '0;
    blk_buf[0] = 12'h040;
    push_exp();
    send_coefs(64, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dc_accept: got timeout expected 64 accepts"); end
    wait_samples(64, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dc_samples: got %0d expected 64", got_q.size()); end
    checks++; if (pulse_cnt - base !== 1) begin errors++; $display("FAIL dc_pulses: got %0d expected 1", pulse_cnt - base); end
    checks++; if (pulse_cyc !== last_acc_cyc + 1) begin errors++; $display("FAIL dc_latency: got cycle %0d expected %0d", pulse_cyc, last_acc_cyc + 1); end
    checks++; if (long_pulse !== lp) begin errors++; $display("FAIL dc_pulse_width: got %0d long pulses expected 0", long_pulse - lp); end
    for (int i = 0; i < 64 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g[PIX_W-1:0] !== e) begin errors++; $display("FAIL dc_data[%0d]: got %h expected %h", i, g[PIX_W-1:0], e); end
      checks++; if (g[PIX_W] !== (i == 63)) begin errors++; $display("FAIL dc_last[%0d]: got %b expected %b", i, g[PIX_W], (i == 63)); end
    end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL dc_extra: got %0d extra samples expected 0", got_q.size()); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok, all_ok, seen;
    int base, rdy_cyc;
    logic [PIX_W:0] g;
    logic [PIX_W-1:0] e;
    base = pulse_cnt; all_ok = 1'b1;
    pix_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rand_block(); push_exp();
      send_coefs(64, 1'b1, ok);
      all_ok = all_ok & ok;
    end
    checks++; if (!all_ok) begin errors++; $display("FAIL b2b_accept: got timeout expected 192 accepts"); end
    // First result parked in the output buffer, blocks two and three fill both banks.
    repeat (4) @(posedge clk);
    #1;
    checks++; if (coef_ready !== 1'b0) begin errors++; $display("FAIL b2b_coef_ready_full: got %b expected 0", coef_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (pulse_cnt - base !== 1) begin errors++; $display("FAIL b2b_pulses_stalled: got %0d expected 1", pulse_cnt - base); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL b2b_no_output: got %0d samples expected 0", got_q.size()); end
    pix_ready = 1'b1;
    seen = 1'b0; rdy_cyc = 0;
    for (int t = 0; t < 600 && !seen; t++) begin
      @(negedge clk);
      if (coef_ready === 1'b1) begin seen = 1'b1; rdy_cyc = cyc; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_ready_return: got timeout expected coef_ready=1"); end
    checks++; if (pulse_cnt - base !== 2) begin errors++; $display("FAIL b2b_second_pulse: got %0d expected 2", pulse_cnt - base); end
    checks++; if (rdy_cyc !== pulse_cyc + 3) begin errors++; $display("FAIL b2b_free_to_ready: got cycle %0d expected %0d", rdy_cyc, pulse_cyc + 3); end
    @(posedge clk); #1;
    wait_samples(192, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_samples: got %0d expected 192", got_q.size()); end
    for (int i = 0; i < 192 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g[PIX_W-1:0] !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, g[PIX_W-1:0], e); end
      checks++; if (g[PIX_W] !== ((i % 64) == 63)) begin errors++; $display("FAIL b2b_last[%0d]: got %b expected %b", i, g[PIX_W], ((i % 64) == 63)); end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pulse_cnt - base !== 3) begin errors++; $display("FAIL b2b_total_pulses: got %0d expected 3", pulse_cnt - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy: got %b expected 0", busy); end
    checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready: got %b expected 1", coef_ready); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_hold_valid();
    bit ok;
    int base;
    logic [PIX_W:0] g;
    logic [PIX_W-1:0] e;
    base = pulse_cnt;
    eng_hold = 5; pix_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      rand_block(); push_exp();
      send_coefs(64, 1'b1, ok);
      checks++; if (!ok) begin errors++; $display("FAIL hold_accept[%0d]: got timeout expected 64 accepts", b); end
      wait_samples(64, ok);
      checks++; if (!ok) begin errors++; $display("FAIL hold_samples[%0d]: got %0d expected 64", b, got_q.size()); end
      repeat (80) @(posedge clk);
      #1;
      checks++; if (got_q.size() !== 64) begin errors++; $display("FAIL hold_capture_count[%0d]: got %0d samples expected 64", b, got_q.size()); end
      checks++; if (pulse_cnt - base !== b + 1) begin errors++; $display("FAIL hold_pulses[%0d]: got %0d expected %0d", b, pulse_cnt - base, b + 1); end
      for (int i = 0; i < 64 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++; if (g[PIX_W-1:0] !== e) begin errors++; $display("FAIL hold_data[%0d][%0d]: got %h expected %h", b, i, g[PIX_W-1:0], e); end
        checks++; if (g[PIX_W] !== (i == 63)) begin errors++; $display("FAIL hold_last[%0d][%0d]: got %b expected %b", b, i, g[PIX_W], (i == 63)); end
      end
      exp_q.delete(); got_q.delete();
      eng_hold = 1;
    end
  endtask

  task automatic test_reset_mid_block();
    bit ok;
    int base;
    logic [PIX_W:0] g;
    logic [PIX_W-1:0] e;
    pix_ready = 1'b0;
    rand_block();
    send_coefs(64, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_first_accept: got timeout expected 64 accepts"); end
    rand_block();
    send_coefs(30, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_partial_accept: got timeout expected 30 accepts"); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (coef_ready !== 1'b1) begin errors++; $display("FAIL rstmid_coef_ready: got %b expected 1", coef_ready); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rstmid_pix_valid: got %b expected 0", pix_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); got_q.delete();
    base = pulse_cnt; pix_ready = 1'b1;
    rand_block(); push_exp();
    send_coefs(64, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_accept: got timeout expected 64 accepts"); end
    wait_samples(64, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_samples: got %0d expected 64", got_q.size()); end
    for (int i = 0; i < 64 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g[PIX_W-1:0] !== e) begin errors++; $display("FAIL rstmid_data[%0d]: got %h expected %h", i, g[PIX_W-1:0], e); end
      checks++; if (g[PIX_W] !== (i == 63)) begin errors++; $display("FAIL rstmid_last[%0d]: got %b expected %b", i, g[PIX_W], (i == 63)); end
    end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rstmid_extra: got %0d extra samples expected 0", got_q.size()); end
    checks++; if (pulse_cnt - base !== 1) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 1", pulse_cnt - base); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_level_shift();
    bit ok;
    logic [PIX_W:0] g, g0, g1;
    logic [PIX_W-1:0] e;
    pix_ready = 1'b1;
    rand_block();
    blk_buf[0] = 12'h080;
    blk_buf[1] = 12'h07E;
    push_exp();
    send_coefs(64, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL shift_accept: got timeout expected 64 accepts"); end
    wait_samples(64, ok);
    checks++; if (!ok) begin errors++; $display("FAIL shift_samples: got %0d expected 64", got_q.size()); end
    g0 = (got_q.size() > 0) ? got_q[0] : 'x;
    g1 = (got_q.size() > 1) ? got_q[1] : 'x;
    checks++; if (g0[PIX_W-1:0] !== LS_LO) begin errors++; $display("FAIL shift_min: got %h expected %h", g0[PIX_W-1:0], LS_LO); end
    checks++; if (g1[PIX_W-1:0] !== LS_HI) begin errors++; $display("FAIL shift_max: got %h expected %h", g1[PIX_W-1:0], LS_HI); end
    for (int i = 0; i < 64 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g[PIX_W-1:0] !== e) begin errors++; $display("FAIL shift_data[%0d]: got %h expected %h", i, g[PIX_W-1:0], e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall_toggle();
    bit ok, prev_stall;
    int xfers;
    logic [PIX_W:0] prev_word, g;
    logic [PIX_W-1:0] e;
    pix_ready = 1'b0;
    rand_block(); push_exp();
    send_coefs(64, 1'b1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_accept: got timeout expected 64 accepts"); end
    xfers = 0; prev_stall = 1'b0; prev_word = '0;
    for (int t = 0; t < 600 && xfers < 64; t++) begin
      pix_ready = ~pix_ready;
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if ({pix_valid, pix_last, pix_data} !== {1'b1, prev_word}) begin
          errors++; $display("FAIL stall_hold[%0d]: got %b/%h expected %b/%h", t, pix_last, pix_data, prev_word[PIX_W], prev_word[PIX_W-1:0]);
        end
      end
      prev_stall = pix_valid && !pix_ready;
      prev_word  = {pix_last, pix_data};
      if (pix_valid && pix_ready) xfers++;
      @(posedge clk); #1;
    end
    pix_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (xfers !== 64) begin errors++; $display("FAIL stall_xfers: got %0d expected 64", xfers); end
    checks++; if (got_q.size() !== 64) begin errors++; $display("FAIL stall_count: got %0d expected 64", got_q.size()); end
    for (int i = 0; i < 64 && got_q.size() > 0 && exp_q.size() > 0; i++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      checks++; if (g[PIX_W-1:0] !== e) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", i, g[PIX_W-1:0], e); end
      checks++; if (g[PIX_W] !== (i == 63)) begin errors++; $display("FAIL stall_last[%0d]: got %b expected %b", i, g[PIX_W], (i == 63)); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_dc_block();
    test_back_to_back();
    test_hold_valid();
    test_reset_mid_block();
    test_level_shift();
    test_stall_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
